// File: rtl/traffic_phase_controller_if.sv
// Signal bundle between the phase controller and its environment:
// detector/pushbutton calls in, lamp drives and status out.
interface traffic_phase_controller_if #(
    parameter int NUM_PHASES = 4
);
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic [NUM_PHASES-1:0] demand;
    logic [NUM_PHASES-1:0] ped;
    logic [NUM_PHASES-1:0] emerg;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] red;
    logic [PH_W-1:0]       active_phase;
    logic                  preempt_active;

    modport master (
        output demand, ped, emerg,
        input  green, yellow, red, active_phase, preempt_active
    );

    modport slave (
        input  demand, ped, emerg,
        output green, yellow, red, active_phase, preempt_active
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// N-phase signal controller: round-robin service of latched calls through
// GREEN -> YELLOW -> ALL-RED, with ped-extended clearance and emergency hold.
module traffic_phase_controller #(
    parameter int NUM_PHASES  = 4,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 25,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 2,
    parameter int T_PED_CLEAR = 10
) (
    input  logic clk,
    input  logic rst,
    traffic_phase_controller_if.slave bus
);
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    // Timer values on the last cycle of each interval.
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(T_PED_CLEAR - 1);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2
    } state_t;

    state_t                r_state;
    logic [PH_W-1:0]       r_active;
    logic [CNT_W-1:0]      r_timer;
    logic [NUM_PHASES-1:0] r_call;
    logic [NUM_PHASES-1:0] r_pcall;
    logic [NUM_PHASES-1:0] r_green;
    logic [NUM_PHASES-1:0] r_yellow;
    logic [NUM_PHASES-1:0] r_red;
    logic                  r_preempt;

    logic                  w_emerg_any;
    logic [PH_W-1:0]       w_emerg_idx;
    logic [PH_W-1:0]       w_rr_idx;
    logic [PH_W-1:0]       w_sel;
    logic                  w_conflict;
    logic                  w_hold;
    logic                  w_green_end;
    logic [CNT_W-1:0]      w_ar_last;
    state_t                w_state_nxt;
    logic [PH_W-1:0]       w_active_nxt;
    logic [CNT_W-1:0]      w_timer_nxt;
    logic [NUM_PHASES-1:0] w_call_clr;
    logic [NUM_PHASES-1:0] w_pcall_clr;
    logic                  w_preempt_nxt;
    logic [NUM_PHASES-1:0] w_green_nxt;
    logic [NUM_PHASES-1:0] w_yellow_nxt;

    function automatic logic [NUM_PHASES-1:0] onehot(input logic [PH_W-1:0] idx);
        logic [NUM_PHASES-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PH_W-1:0] lowest_idx(input logic [NUM_PHASES-1:0] v);
        logic [PH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (v[i]) idx = PH_W'(i);
        end
        return idx;
    endfunction

    // First called phase after cur in rotation order; cur+1 if none is called.
    function automatic logic [PH_W-1:0] rr_next(input logic [NUM_PHASES-1:0] c,
                                                input logic [PH_W-1:0]       cur);
        logic [PH_W-1:0] idx;
        int              j;
        idx = PH_W'((int'(cur) + 1) % NUM_PHASES);
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            j = (int'(cur) + k) % NUM_PHASES;
            if (c[j]) idx = PH_W'(j);
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] t);
        return (t == {CNT_W{1'b1}}) ? t : t + CNT_W'(1);
    endfunction

    always_comb begin
        w_emerg_any = |bus.emerg;
        w_emerg_idx = lowest_idx(bus.emerg);
        w_rr_idx    = rr_next(r_call, r_active);
        w_sel       = w_emerg_any ? w_emerg_idx : w_rr_idx;
        w_conflict  = |(r_call & ~onehot(r_active));
        w_hold      = (r_state == S_GREEN) && w_emerg_any && (w_emerg_idx == r_active);
        w_green_end = !w_hold &&
                      ((w_conflict && (r_timer >= MIN_LAST) &&
                        ((r_timer >= MAX_LAST) || !bus.demand[r_active])) ||
                       w_emerg_any);
        // Ped extension is dropped as soon as any emergency shows up.
        w_ar_last   = (r_pcall[r_active] && !w_emerg_any) ? PED_LAST : AR_LAST;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_timer_nxt  = r_timer;
        w_call_clr   = '0;
        w_pcall_clr  = '0;
        case (r_state)
            S_GREEN: begin
                if (w_hold) begin
                    w_timer_nxt = r_timer;
                end else if (w_green_end) begin
                    w_state_nxt = S_YELLOW;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = sat_inc(r_timer);
                end
            end
            S_YELLOW: begin
                if (r_timer >= YEL_LAST) begin
                    w_state_nxt = S_ALLRED;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            S_ALLRED: begin
                // >= so a late emergency cutting the ped extension still exits.
                if (r_timer >= w_ar_last) begin
                    w_state_nxt  = S_GREEN;
                    w_active_nxt = w_sel;
                    w_timer_nxt  = '0;
                    w_call_clr   = onehot(w_sel);
                    w_pcall_clr  = onehot(r_active);
                end else begin
                    w_timer_nxt = r_timer + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_GREEN;
                w_timer_nxt = '0;
            end
        endcase

        w_preempt_nxt = (w_state_nxt == S_GREEN) && w_emerg_any &&
                        (w_emerg_idx == w_active_nxt);
        w_green_nxt   = (w_state_nxt == S_GREEN)  ? onehot(w_active_nxt) : '0;
        w_yellow_nxt  = (w_state_nxt == S_YELLOW) ? onehot(w_active_nxt) : '0;
    end

    // Lamps are registered from the next-state view so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_GREEN;
            r_active  <= '0;
            r_timer   <= '0;
            r_call    <= '0;
            r_pcall   <= '0;
            r_preempt <= 1'b0;
            r_green   <= onehot('0);
            r_yellow  <= '0;
            r_red     <= ~onehot('0);
        end else begin
            r_state   <= w_state_nxt;
            r_active  <= w_active_nxt;
            r_timer   <= w_timer_nxt;
            r_call    <= (r_call | bus.demand) & ~w_call_clr;
            r_pcall   <= (r_pcall | bus.ped) & ~w_pcall_clr;
            r_preempt <= w_preempt_nxt;
            r_green   <= w_green_nxt;
            r_yellow  <= w_yellow_nxt;
            r_red     <= ~(w_green_nxt | w_yellow_nxt);
        end
    end

    assign bus.green          = r_green;
    assign bus.yellow         = r_yellow;
    assign bus.red            = r_red;
    assign bus.active_phase   = r_active;
    assign bus.preempt_active = r_preempt;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: directed scenarios plus
// randomized traffic against an interval-level reference model.
module tb_traffic_phase_controller;
    localparam int NP    = 4;
    localparam int CW    = 8;
    localparam int TMIN  = 10;
    localparam int TMAX  = 25;
    localparam int TY    = 4;
    localparam int TAR   = 2;
    localparam int TPC   = 10;
    localparam int PW    = 2;
    localparam int OUT_W = 3 * NP + PW + 1;
    localparam int MG = 0, MY = 1, MA = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_phase_controller_if #(.NUM_PHASES(NP)) bus();

    traffic_phase_controller #(
        .NUM_PHASES(NP), .CNT_W(CW), .T_MIN_GREEN(TMIN), .T_MAX_GREEN(TMAX),
        .T_YELLOW(TY), .T_ALLRED(TAR), .T_PED_CLEAR(TPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: which interval we are in, who owns it, and how long it has run.
    int           m_st, m_act, m_age, m_left, m_spent;
    logic [NP-1:0] m_call, m_pcall;
    logic          m_pre;

    task automatic model_reset();
        m_st = MG; m_act = 0; m_age = 0; m_left = 0; m_spent = 0;
        m_call = '0; m_pcall = '0; m_pre = 1'b0;
    endtask

    task automatic model_step(input logic [NP-1:0] d, input logic [NP-1:0] p,
                              input logic [NP-1:0] e);
        logic [NP-1:0] nc, npc;
        int le, nxt;
        bit conflict;
        nc = m_call | d;
        npc = m_pcall | p;
        le = -1;
        for (int i = NP - 1; i >= 0; i--) if (e[i]) le = i;
        case (m_st)
            MG: begin
                conflict = 1'b0;
                for (int j = 0; j < NP; j++) if (j != m_act && m_call[j]) conflict = 1'b1;
                if (le == m_act) begin
                    m_pre = 1'b1;
                end else if (le >= 0 || (conflict && m_age + 1 >= TMIN &&
                                         (m_age + 1 >= TMAX || !d[m_act]))) begin
                    m_st = MY; m_left = TY; m_pre = 1'b0;
                end else begin
                    m_age = (m_age < 255) ? m_age + 1 : m_age;
                    m_pre = 1'b0;
                end
            end
            MY: begin
                m_left--;
                if (m_left == 0) begin m_st = MA; m_spent = 0; end
            end
            default: begin
                m_spent++;
                if (m_spent >= ((m_pcall[m_act] && le < 0) ? TPC : TAR)) begin
                    if (le >= 0) nxt = le;
                    else begin
                        nxt = (m_act + 1) % NP;
                        for (int k = NP - 1; k >= 1; k--)
                            if (m_call[(m_act + k) % NP]) nxt = (m_act + k) % NP;
                    end
                    npc[m_act] = 1'b0;
                    nc[nxt] = 1'b0;
                    m_act = nxt; m_st = MG; m_age = 0; m_pre = (le >= 0);
                end
            end
        endcase
        m_call = nc;
        m_pcall = npc;
    endtask

    function automatic logic [OUT_W-1:0] model_out();
        logic [NP-1:0] g, y;
        g = '0; y = '0;
        if (m_st == MG) g[m_act] = 1'b1;
        else if (m_st == MY) y[m_act] = 1'b1;
        return {g, y, ~(g | y), PW'(m_act), m_pre};
    endfunction

    function automatic logic [OUT_W-1:0] dut_out();
        return {bus.green, bus.yellow, bus.red, bus.active_phase, bus.preempt_active};
    endfunction

    task automatic step(input logic [NP-1:0] d, input logic [NP-1:0] p,
                        input logic [NP-1:0] e, input logic r);
        bus.demand = d; bus.ped = p; bus.emerg = e; rst = r;
        if (r) model_reset();
        else model_step(d, p, e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [OUT_W-1:0] exp;
        exp = {4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0};
        step('0, '0, '0, 1'b1);
        for (int c = 0; c <= 100; c++) begin
            checks++;
            if (dut_out() !== exp) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, dut_out(), exp);
            end
            step('0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_max_green();
        step('0, '0, '0, 1'b1);
        for (int c = 0; c < 40; c++) begin
            step((c == 0) ? 4'b0101 : 4'b0001, '0, '0, 1'b0);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL max_green cyc=%0d got=%h exp=%h", c + 1, dut_out(), model_out());
            end
            if (c + 1 == 24 || c + 1 == 25 || c + 1 == 28 || c + 1 == 29 || c + 1 == 31) begin
                checks++;
                if ({bus.green, bus.yellow} !== ((c + 1 == 24) ? 8'b0001_0000 :
                                                 (c + 1 == 29) ? 8'b0000_0000 :
                                                 (c + 1 == 31) ? 8'b0100_0000 : 8'b0000_0001)) begin
                    errors++;
                    $display("FAIL max_green_lamp cyc=%0d got g=%b y=%b", c + 1, bus.green, bus.yellow);
                end
            end
        end
    endtask

    task automatic test_min_green();
        step('0, '0, '0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step((c == 0) ? 4'b0100 : 4'b0000, '0, '0, 1'b0);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL min_green cyc=%0d got=%h exp=%h", c + 1, dut_out(), model_out());
            end
            if (c + 1 == 9 || c + 1 == 10) begin
                checks++;
                if (bus.yellow[0] !== (c + 1 == 10)) begin
                    errors++;
                    $display("FAIL min_green_yellow0 cyc=%0d got=%b exp=%b", c + 1, bus.yellow[0], c + 1 == 10);
                end
            end
        end
    endtask

    task automatic test_ped_clear();
        step('0, '0, '0, 1'b1);
        for (int c = 0; c < 30; c++) begin
            step((c == 0) ? 4'b0010 : 4'b0000, (c == 0 || c == 5) ? 4'b0001 : 4'b0000, '0, 1'b0);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL ped_clear cyc=%0d got=%h exp=%h", c + 1, dut_out(), model_out());
            end
            if (c + 1 == 23 || c + 1 == 24) begin
                checks++;
                if (bus.green !== ((c + 1 == 24) ? 4'b0010 : 4'b0000)) begin
                    errors++;
                    $display("FAIL ped_allred_len cyc=%0d got=%b", c + 1, bus.green);
                end
            end
        end
    endtask

    task automatic test_emerg();
        step('0, '0, '0, 1'b1);
        for (int c = 0; c < 60; c++) begin
            step((c == 0) ? 4'b0010 : 4'b0000, (c == 17) ? 4'b0010 : 4'b0000,
                 (c >= 19 && c < 46) ? 4'b1000 : 4'b0000, 1'b0);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL emerg cyc=%0d got=%h exp=%h", c + 1, dut_out(), model_out());
            end
            if (c + 1 == 20 || c + 1 == 26 || c + 1 == 45) begin
                checks++;
                if ({bus.green, bus.yellow, bus.preempt_active} !==
                    ((c + 1 == 20) ? 9'b0000_0010_0 : 9'b1000_0000_1)) begin
                    errors++;
                    $display("FAIL emerg_key cyc=%0d got g=%b y=%b pre=%b", c + 1,
                             bus.green, bus.yellow, bus.preempt_active);
                end
            end
        end
    endtask

    task automatic test_multi_emerg();
        step('0, '0, '0, 1'b1);
        for (int c = 0; c < 70; c++) begin
            step('0, '0, (c < 30) ? 4'b0110 : (c < 55) ? 4'b0100 : 4'b0000, 1'b0);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL multi_emerg cyc=%0d got=%h exp=%h", c + 1, dut_out(), model_out());
            end
            if (c + 1 == 7) begin
                checks++;
                if ({bus.active_phase, bus.preempt_active, bus.green} !== 7'b01_1_0010) begin
                    errors++;
                    $display("FAIL multi_emerg_low cyc=7 got act=%0d pre=%b g=%b",
                             bus.active_phase, bus.preempt_active, bus.green);
                end
            end
        end
    endtask

    task automatic test_order_and_reset();
        logic [NP-1:0] d;
        step('0, '0, '0, 1'b1);
        for (int c = 0; c < 90; c++) begin
            d = (c == 0) ? 4'b0100 : (c == 17) ? 4'b1010 : (c == 50) ? 4'b0001 :
                (c == 58) ? 4'b0100 : 4'b0000;
            step(d, '0, '0, c == 59);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL order cyc=%0d got=%h exp=%h", c + 1, dut_out(), model_out());
            end
            if (c + 1 == 32 || c + 1 == 48 || c + 1 == 59 || c + 1 == 60 || c + 1 == 90) begin
                checks++;
                if ({bus.green, bus.yellow} !== ((c + 1 == 32) ? 8'b1000_0000 :
                                                 (c + 1 == 48) ? 8'b0010_0000 :
                                                 (c + 1 == 59) ? 8'b0000_0010 : 8'b0001_0000)) begin
                    errors++;
                    $display("FAIL order_key cyc=%0d got g=%b y=%b", c + 1, bus.green, bus.yellow);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] d, p, e;
        e = '0;
        step('0, '0, '0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            d = '0; p = '0;
            for (int i = 0; i < NP; i++) begin
                d[i] = ($urandom_range(0, 9) == 0);
                p[i] = ($urandom_range(0, 19) == 0);
            end
            if (e == '0 && $urandom_range(0, 149) == 0) e = NP'($urandom_range(1, 15));
            else if (e != '0 && $urandom_range(0, 39) == 0) e = '0;
            step(d, p, e, $urandom_range(0, 699) == 0);
            checks++;
            if (dut_out() !== model_out()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c + 1, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        bus.demand = '0; bus.ped = '0; bus.emerg = '0;
        model_reset();
        test_reset();
        test_max_green();
        test_min_green();
        test_ped_clear();
        test_emerg();
        test_multi_emerg();
        test_order_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
